// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronised edge-detected sources, mask, fixed priority, CPU handshake.
// Build option IRQ_CTRL_LEVEL_EN adds per-source level mode (CTRL bits [8+N_SRC-1:8]).
module irq_ctrl #(
    parameter int unsigned N_SRC = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sel,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [1:0]       i_addr,
    input  logic [15:0]      i_wdata,
    output logic [15:0]      o_rdata,
    output logic             o_rdy,
    input  logic [N_SRC-1:0] i_irq,
    output logic             o_irq,
    output logic [2:0]       o_vec,
    input  logic             i_ack,
    input  logic             i_iret
);
    localparam int unsigned DW = 16;
    localparam int unsigned VW = 3;
    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;
    logic             irq_q, irq_d;
    logic [VW-1:0]    vec_q, vec_d;

    logic             wr_c;
    logic             wr_pend_c, wr_mask_c, wr_ctrl_c;
    logic [N_SRC-1:0] level_mode_c;
    logic [N_SRC-1:0] edge_set_c, w1c_c, ack_clr_c;
    logic [N_SRC-1:0] vec_onehot_c, req_c;
    logic [VW-1:0]    win_c;
    logic             cur_valid_c;
    logic             unused_wdata;

    assign unused_wdata = ^i_wdata;

    assign wr_c      = i_sel & i_we;
    assign wr_pend_c = wr_c && (i_addr == A_PEND);
    assign wr_mask_c = wr_c && (i_addr == A_MASK);
    assign wr_ctrl_c = wr_c && (i_addr == A_CTRL);

`ifdef IRQ_CTRL_LEVEL_EN
    logic [N_SRC-1:0] level_q, level_d;

    always_comb level_d = wr_ctrl_c ? i_wdata[8 +: N_SRC] : level_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) level_q <= '0;
        else       level_q <= level_d;
    end

    assign level_mode_c = level_q;
`else
    assign level_mode_c = '0;
`endif

    // Input path and register updates; an edge-set always beats a same-cycle clear.
    always_comb begin
        sync1_d      = i_irq;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        edge_set_c   = sync2_q & ~prev_q;
        vec_onehot_c = N_SRC'(1) << vec_q;
        w1c_c        = wr_pend_c ? i_wdata[N_SRC-1:0] : '0;
        ack_clr_c    = ((state_q == REQ) && i_ack) ? vec_onehot_c : '0;
        pend_d       = (pend_q & ~w1c_c & ~ack_clr_c) | edge_set_c;
        pend_d       = (pend_d & ~level_mode_c) | (sync2_q & level_mode_c);
        mask_d       = wr_mask_c ? i_wdata[N_SRC-1:0] : mask_q;
        gie_d        = wr_ctrl_c ? i_wdata[0] : gie_q;
    end

    // Lowest-index enabled pending source wins.
    always_comb begin
        req_c = pend_q & mask_q;
        win_c = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_c[i]) win_c = VW'(i);
        end
    end

    assign cur_valid_c = gie_q && ((pend_q & mask_q & vec_onehot_c) != '0);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        irq_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gie_q && (req_c != '0)) begin
                    state_d = REQ;
                    vec_d   = win_c;
                end
            end
            REQ: begin
                if (i_ack)             state_d = SERVICE;
                else if (!cur_valid_c) state_d = IDLE;
            end
            SERVICE: begin
                if (i_iret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQ);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            irq_q   <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
        end
    end

    // Combinational read port.
    always_comb begin
        o_rdata = '0;
        if (i_sel && i_re) begin
            case (i_addr)
                A_PEND:  o_rdata = DW'(pend_q);
                A_MASK:  o_rdata = DW'(mask_q);
                A_STAT:  o_rdata = {state_q == SERVICE, irq_q, 11'b0, vec_q};
                A_CTRL:  o_rdata = DW'(gie_q) | (DW'(level_mode_c) << 8);
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_rdy = i_sel;
    assign o_irq = irq_q;
    assign o_vec = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed + randomized bench for irq_ctrl against a cycle-level reference model of the register/handshake rules.
module tb_irq_ctrl;
    localparam int unsigned FULL  = 32'h0000_00FF;
    localparam int unsigned S_IDLE = 0;
    localparam int unsigned S_REQ  = 1;
    localparam int unsigned S_SVC  = 2;
`ifdef IRQ_CTRL_LEVEL_EN
    localparam logic [15:0] CTRL_FF01 = 16'hFF01;
`else
    localparam logic [15:0] CTRL_FF01 = 16'h0001;
`endif

    logic        clk;
    logic        i_rst, i_sel, i_we, i_re, i_ack, i_iret;
    logic [1:0]  i_addr;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;
    logic        o_rdy, o_irq;
    logic [2:0]  o_vec;
    logic [7:0]  i_irq;

    int n_cmp;
    int n_fail;

    // Reference model state (values as seen after the most recent edge).
    int unsigned m_pend, m_mask, m_level, m_vec, m_state;
    bit          m_gie, m_irq;
    int unsigned h0, h1, h2;  // raw i_irq samples at the last three edges

    irq_ctrl #(.N_SRC(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_sel(i_sel), .i_we(i_we), .i_re(i_re),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy),
        .i_irq(i_irq), .o_irq(o_irq), .o_vec(o_vec), .i_ack(i_ack), .i_iret(i_iret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_level = 0; m_vec = 0; m_state = S_IDLE;
        m_gie = 1'b0; m_irq = 1'b0; h0 = 0; h1 = 0; h2 = 0;
    endtask

    // Apply the driven inputs of this cycle to the model, as the next edge will.
    task automatic model_edge();
        int unsigned w1c, ackc, req, nxt_pend, nxt_state, wd;
        bit wr;
        wr   = i_sel && i_we;
        wd   = 32'(i_wdata);
        w1c  = (wr && i_addr == 2'd0) ? (wd & FULL) : 0;
        ackc = (m_state == S_REQ && i_ack) ? (32'd1 << m_vec) : 0;
        nxt_pend = (m_pend & ~w1c & ~ackc) | (h1 & ~h2 & FULL);
        nxt_pend = (nxt_pend & ~m_level) | (h1 & m_level);
        req = m_pend & m_mask;
        nxt_state = m_state;
        if (m_state == S_IDLE) begin
            if (m_gie && req != 0) begin
                nxt_state = S_REQ;
                m_vec = 32'($clog2(req & (~req + 1)));
            end
        end else if (m_state == S_REQ) begin
            if (i_ack) nxt_state = S_SVC;
            else if (((req >> m_vec) & 1) == 0 || !m_gie) nxt_state = S_IDLE;
        end else if (i_iret) begin
            nxt_state = S_IDLE;
        end
        if (wr && i_addr == 2'd1) m_mask = wd & FULL;
        if (wr && i_addr == 2'd3) begin
            m_gie = i_wdata[0];
`ifdef IRQ_CTRL_LEVEL_EN
            m_level = (wd >> 8) & FULL;
`endif
        end
        m_pend  = nxt_pend;
        m_state = nxt_state;
        m_irq   = (nxt_state == S_REQ);
        h2 = h1; h1 = h0; h0 = 32'(i_irq);
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 16'(m_pend);
            2'd1:    return 16'(m_mask);
            2'd2:    return {m_state == S_SVC, m_irq, 11'b0, 3'(m_vec)};
            default: return 16'(m_gie) | 16'(m_level << 8);
        endcase
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("irq", 16'(o_irq), 16'(m_irq));
        check("vec", 16'(o_vec), 16'(m_vec));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
        step();
        i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
        i_sel = 1'b1; i_re = 1'b1; i_addr = a;
        #1;
        check(tag, o_rdata, exp);
        i_sel = 1'b0; i_re = 1'b0;
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1; step(); i_ack = 1'b0;
    endtask

    task automatic pulse_iret();
        i_iret = 1'b1; step(); i_iret = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        i_irq = v; step(); i_irq = '0;
    endtask

    initial begin
        logic [1:0] ra;
        n_cmp = 0; n_fail = 0;
        i_rst = 1'b1; i_sel = 0; i_we = 0; i_re = 0; i_ack = 0; i_iret = 0;
        i_addr = '0; i_wdata = '0; i_irq = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", 16'(o_irq), 16'h0);
        check("rst_vec", 16'(o_vec), 16'h0);
        i_rst = 1'b0;
        for (int a = 0; a < 4; a++) rd_check("rst_reg", 2'(a), 16'h0000);
        check("rdy_idle", 16'(o_rdy), 16'h0);

        // Basic flow
        bus_write(2'd1, 16'h0004);
        bus_write(2'd3, 16'h0001);
        pulse_irq(8'h04);
        step();
        rd_check("pend_edge2", 2'd0, 16'h0000);
        step();
        rd_check("pend_edge3", 2'd0, 16'h0004);
        check("irq_edge3", 16'(o_irq), 16'h0);
        step();
        check("irq_edge4", 16'(o_irq), 16'h1);
        check("vec_edge4", 16'(o_vec), 16'h2);
        pulse_ack();
        rd_check("pend_ack", 2'd0, 16'h0000);
        rd_check("stat_svc", 2'd2, 16'h8002);
        pulse_iret();
        rd_check("stat_iret", 2'd2, 16'h0002);

        // Held-high line pends once only
        i_irq = 8'h04;
        repeat (4) step();
        check("held_irq", 16'(o_irq), 16'h1);
        pulse_ack();
        pulse_iret();
        repeat (2) step();
        check("held_once", 16'(o_irq), 16'h0);
        i_irq = '0;
        repeat (3) step();

        // Priority and freeze
        bus_write(2'd1, 16'h00FF);
        pulse_irq(8'h22);
        repeat (3) step();
        check("prio_vec", 16'(o_vec), 16'h1);
        pulse_irq(8'h01);
        repeat (3) step();
        check("freeze_vec", 16'(o_vec), 16'h1);
        check("freeze_irq", 16'(o_irq), 16'h1);
        rd_check("freeze_pend", 2'd0, 16'h0023);
        pulse_ack();
        pulse_iret();
        check("rereq_gap", 16'(o_irq), 16'h0);
        step();
        check("rereq_irq", 16'(o_irq), 16'h1);
        check("rereq_vec", 16'(o_vec), 16'h0);
        pulse_ack();
        bus_write(2'd0, 16'h00FF);
        pulse_iret();
        repeat (2) step();
        rd_check("prio_clean", 2'd0, 16'h0000);

        // Withdraw and re-request
        pulse_irq(8'h08);
        repeat (3) step();
        check("wd_vec", 16'(o_vec), 16'h3);
        bus_write(2'd1, 16'h0000);
        step();
        check("wd_irq", 16'(o_irq), 16'h0);
        rd_check("wd_stat", 2'd2, 16'h0003);
        bus_write(2'd1, 16'h0008);
        step();
        check("wd_back_irq", 16'(o_irq), 16'h1);
        check("wd_back_vec", 16'(o_vec), 16'h3);

        // Asynchronous reset mid-REQ
        #1 i_rst = 1'b1;
        #1;
        check("arst_irq", 16'(o_irq), 16'h0);
        check("arst_vec", 16'(o_vec), 16'h0);
        for (int a = 0; a < 4; a++) rd_check("arst_reg", 2'(a), 16'h0000);
        i_rst = 1'b0;
        model_reset();

        // Edge-set beats same-cycle W1C; read strobe gating
        pulse_irq(8'h01);
        step();
        bus_write(2'd0, 16'h0001);
        rd_check("collide_pend", 2'd0, 16'h0001);
        i_sel = 1'b1; i_re = 1'b0; i_addr = 2'd0;
        #1;
        check("no_re_rdata", o_rdata, 16'h0000);
        check("rdy_sel", 16'(o_rdy), 16'h1);
        i_sel = 1'b0;
        bus_write(2'd0, 16'h0001);
        rd_check("w1c_pend", 2'd0, 16'h0000);
        bus_write(2'd2, 16'hFFFF);
        rd_check("stat_ro", 2'd2, 16'h0000);
        bus_write(2'd3, 16'hFF01);
        rd_check("ctrl_rd", 2'd3, CTRL_FF01);
        bus_write(2'd3, 16'h0000);

`ifdef IRQ_CTRL_LEVEL_EN
        // Level-mode source re-requests while held
        bus_write(2'd1, 16'h0001);
        bus_write(2'd3, 16'h0101);
        i_irq = 8'h01;
        repeat (4) step();
        check("lvl_irq", 16'(o_irq), 16'h1);
        pulse_ack();
        pulse_iret();
        step();
        check("lvl_reirq", 16'(o_irq), 16'h1);
        check("lvl_revec", 16'(o_vec), 16'h0);
        i_irq = '0;
        pulse_ack();
        repeat (3) step();
        bus_write(2'd0, 16'h0001);
        pulse_iret();
        step();
        rd_check("lvl_pend", 2'd0, 16'h0000);
        bus_write(2'd3, 16'h0000);
`endif

        // Randomized traffic against the model
        bus_write(2'd1, 16'($urandom_range(255)));
        bus_write(2'd3, 16'h0001);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(3) == 0) i_irq = i_irq ^ 8'(1 << $urandom_range(7));
            i_ack  = ($urandom_range(2) == 0);
            i_iret = ($urandom_range(2) == 0);
            if ($urandom_range(7) == 0) begin
                i_sel = 1'b1; i_we = 1'b1;
                i_addr  = 2'($urandom_range(3));
                i_wdata = 16'($urandom);
                if (i_addr == 2'd3) i_wdata[0] = ($urandom_range(3) != 0);
            end
            step();
            i_sel = 1'b0; i_we = 1'b0; i_ack = 1'b0; i_iret = 1'b0;
            ra = 2'($urandom_range(3));
            rd_check("rand_reg", ra, m_read(ra));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
